// File: rtl/fabric_mem_load_resp.sv
// fabric_mem_load_resp
//   Memory-side responder for the load PE protocol. Accepts load addresses,
//   issues reads to a synchronous fixed-latency SRAM, buffers returned words
//   in a response FIFO and delivers them in acceptance order. A credit
//   counter (in-flight reads + FIFO entries) gates new requests so read
//   data is never dropped under response backpressure.
//
// Ports
//   clk          clock
//   rst          synchronous active-high reset
//   req_valid    load address valid
//   req_ready    load address accepted (credit available)
//   req_data     load address (word index)
//   mem_rd_en    SRAM read strobe
//   mem_rd_addr  SRAM read address
//   mem_rd_data  SRAM data, valid RD_LATENCY cycles after mem_rd_en
//   resp_valid   load data valid
//   resp_ready   load data consumer ready
//   resp_data    load data
//   err_oob      sticky flag: an out-of-range address was seen
module fabric_mem_load_resp #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 10,
  parameter int MEM_DEPTH   = 1024,
  parameter int RD_LATENCY  = 2,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  err_oob
);

  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam logic [CNT_W-1:0]    CREDITS     = CNT_W'(QUEUE_DEPTH);
  localparam logic [PTR_W-1:0]    PTR_LAST    = PTR_W'(QUEUE_DEPTH - 1);
  // One extra bit so MEM_DEPTH == 2**DATA_WIDTH is still representable.
  localparam logic [DATA_WIDTH:0] DEPTH_LIMIT = (DATA_WIDTH + 1)'(MEM_DEPTH);

  logic [CNT_W-1:0]      outstanding;
  logic [CNT_W-1:0]      fifo_count;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [DATA_WIDTH-1:0] fifo_mem [QUEUE_DEPTH];
  logic [RD_LATENCY-1:0] pipe_vld;
  logic [RD_LATENCY-1:0] pipe_oob;

  logic                  in_range;
  logic                  accept;
  logic                  resp_fire;
  logic                  fifo_wr;
  logic                  fifo_wr_oob;
  logic [DATA_WIDTH-1:0] fifo_wdata;

  // Range check on the full request word, not the truncated SRAM address.
  assign in_range    = ({1'b0, req_data} < DEPTH_LIMIT);
  assign req_ready   = !rst && (outstanding < CREDITS);
  assign accept      = req_valid && req_ready;
  assign mem_rd_en   = accept && in_range;
  assign mem_rd_addr = req_data[ADDR_WIDTH-1:0];

  assign resp_valid  = !rst && (fifo_count != '0);
  assign resp_data   = fifo_mem[rd_ptr];
  assign resp_fire   = resp_valid && resp_ready;

  // The last pipeline stage lines up with the SRAM data return.
  assign fifo_wr     = pipe_vld[RD_LATENCY-1];
  assign fifo_wr_oob = pipe_oob[RD_LATENCY-1];
  assign fifo_wdata  = fifo_wr_oob ? '0 : mem_rd_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_vld    <= '0;
      pipe_oob    <= '0;
      outstanding <= '0;
      fifo_count  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      err_oob     <= 1'b0;
    end else begin
      pipe_vld[0] <= accept;
      pipe_oob[0] <= accept && !in_range;
      for (int unsigned i = 1; i < unsigned'(RD_LATENCY); i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_oob[i] <= pipe_oob[i-1];
      end

      if (accept && !resp_fire) begin
        outstanding <= outstanding + 1'b1;
      end else if (!accept && resp_fire) begin
        outstanding <= outstanding - 1'b1;
      end

      if (fifo_wr && !resp_fire) begin
        fifo_count <= fifo_count + 1'b1;
      end else if (!fifo_wr && resp_fire) begin
        fifo_count <= fifo_count - 1'b1;
      end

      if (fifo_wr) begin
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (resp_fire) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      end

      if (fifo_wr && fifo_wr_oob) begin
        err_oob <= 1'b1;
      end
    end
  end

  // Storage needs no reset; occupancy is tracked by fifo_count.
  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      fifo_mem[wr_ptr] <= fifo_wdata;
    end
  end

endmodule

// File: tb/tb_fabric_mem_load_resp.sv
module tb_fabric_mem_load_resp;
  localparam int DW = 32;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [DW-1:0] req_data;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [DW-1:0] mem_rd_data;
  logic          resp_valid;
  logic          resp_ready;
  logic [DW-1:0] resp_data;
  logic          err_oob;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fabric_mem_load_resp #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .MEM_DEPTH  (1000),
    .RD_LATENCY (2),
    .QUEUE_DEPTH(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .mem_rd_en  (mem_rd_en),
    .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .err_oob    (err_oob)
  );

  // SRAM model, 2-cycle read latency; garbage returned when not read.
  logic [DW-1:0] sram [1024];
  logic [DW-1:0] sram_d1;
  always @(posedge clk) begin
    sram_d1     <= mem_rd_en ? sram[mem_rd_addr] : 32'hBAD0_BAD0;
    mem_rd_data <= sram_d1;
  end

  function automatic logic [31:0] word(input int a);
    if (a == 5) return 32'hDEAD_BEEF;
    return 32'h1000_0000 + a;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = 1'b1; req_data = '0; resp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick; #1;
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
      checks++; if (mem_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b want 0", mem_rd_en); end
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
    end
    rst = 1'b0; req_valid = 1'b0;
    tick; #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_release_valid: got %b want 0", resp_valid); end
    checks++; if (err_oob !== 1'b0) begin errors++; $display("FAIL reset_err_oob: got %b want 0", err_oob); end
  endtask

  task automatic test_single;
    tick; req_valid = 1'b1; req_data = 5; resp_ready = 1'b0; #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b want 1", req_ready); end
    checks++; if (mem_rd_en !== 1'b1) begin errors++; $display("FAIL single_rd_en: got %b want 1", mem_rd_en); end
    checks++; if (mem_rd_addr !== 10'd5) begin errors++; $display("FAIL single_rd_addr: got %0d want 5", mem_rd_addr); end
    tick; req_valid = 1'b0; #1;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL single_early_t1: got %b want 0", resp_valid); end
    tick; #1;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL single_early_t2: got %b want 0", resp_valid); end
    tick; #1;
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL single_valid_t3: got %b want 1", resp_valid); end
    checks++; if (resp_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_data: got %h want deadbeef", resp_data); end
    tick; #1;
    checks++; if (resp_valid !== 1'b1 || resp_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_hold: got %b/%h want 1/deadbeef", resp_valid, resp_data); end
    resp_ready = 1'b1;
    tick; #1;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL single_pop: got %b want 0", resp_valid); end
  endtask

  task automatic test_stream;
    resp_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick;
      if (c < 16) begin req_valid = 1'b1; req_data = c; end
      else req_valid = 1'b0;
      #1;
      if (c < 16) begin
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL stream_ready c=%0d: got %b want 1", c, req_ready); end
      end
      if (c >= 3 && c < 19) begin
        checks++; if (resp_valid !== 1'b1 || resp_data !== word(c - 3)) begin errors++; $display("FAIL stream_resp c=%0d: got %b/%h want 1/%h", c, resp_valid, resp_data, word(c - 3)); end
      end else begin
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL stream_idle c=%0d: got %b want 0", c, resp_valid); end
      end
    end
  endtask

  task automatic test_backpressure;
    int accepted = 0;
    int got = 0;
    resp_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick; req_valid = 1'b1; req_data = 10 + accepted; #1;
      if (req_ready) accepted++;
    end
    checks++; if (accepted !== 4) begin errors++; $display("FAIL bp_accepted: got %0d want 4", accepted); end
    for (int c = 0; c < 3; c++) begin
      tick; #1;
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_low: got %b want 0", req_ready); end
      checks++; if (resp_valid !== 1'b1 || resp_data !== word(10)) begin errors++; $display("FAIL bp_head_stable: got %b/%h want 1/%h", resp_valid, resp_data, word(10)); end
    end
    for (int c = 0; c < 40 && got < 6; c++) begin
      tick;
      resp_ready = 1'b1;
      req_valid = (accepted < 6);
      req_data = 10 + accepted;
      #1;
      if (resp_valid) begin
        checks++; if (resp_data !== word(10 + got)) begin errors++; $display("FAIL bp_order n=%0d: got %h want %h", got, resp_data, word(10 + got)); end
        got++;
      end
      if (req_valid && req_ready) accepted++;
    end
    checks++; if (got !== 6) begin errors++; $display("FAIL bp_resp_count: got %0d want 6", got); end
    checks++; if (accepted !== 6) begin errors++; $display("FAIL bp_total_accepted: got %0d want 6", accepted); end
    tick; req_valid = 1'b0; #1;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL bp_drained: got %b want 0", resp_valid); end
  endtask

  task automatic test_oob;
    logic [31:0] addrs [4];
    logic        exp_en [4];
    logic [31:0] exp_rsp [4];
    addrs   = '{32'd999, 32'd1000, 32'h0001_0003, 32'd3};
    exp_en  = '{1'b1, 1'b0, 1'b0, 1'b1};
    exp_rsp = '{word(999), 32'h0, 32'h0, word(3)};
    resp_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick;
      if (c < 4) begin req_valid = 1'b1; req_data = addrs[c]; end
      else req_valid = 1'b0;
      #1;
      if (c == 0) begin
        checks++; if (err_oob !== 1'b0) begin errors++; $display("FAIL oob_clear_before: got %b want 0", err_oob); end
      end
      if (c < 4) begin
        checks++; if (mem_rd_en !== exp_en[c]) begin errors++; $display("FAIL oob_rd_en c=%0d: got %b want %b", c, mem_rd_en, exp_en[c]); end
        if (exp_en[c]) begin
          checks++; if (mem_rd_addr !== addrs[c][AW-1:0]) begin errors++; $display("FAIL oob_rd_addr c=%0d: got %0d want %0d", c, mem_rd_addr, addrs[c][AW-1:0]); end
        end
      end
      if (c >= 3 && c < 7) begin
        checks++; if (resp_valid !== 1'b1 || resp_data !== exp_rsp[c-3]) begin errors++; $display("FAIL oob_resp c=%0d: got %b/%h want 1/%h", c, resp_valid, resp_data, exp_rsp[c-3]); end
      end
      if (c >= 4) begin
        checks++; if (err_oob !== 1'b1) begin errors++; $display("FAIL oob_sticky c=%0d: got %b want 1", c, err_oob); end
      end
    end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL oob_drained: got %b want 0", resp_valid); end
  endtask

  task automatic test_midreset;
    int accepted = 0;
    int got = 0;
    resp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick; req_valid = 1'b1; req_data = c + 1; #1;
    end
    tick; req_valid = 1'b0; rst = 1'b1; #1;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid_in_rst: got %b want 0", resp_valid); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready_in_rst: got %b want 0", req_ready); end
    tick; rst = 1'b0; #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready_after: got %b want 1", req_ready); end
    checks++; if (err_oob !== 1'b0) begin errors++; $display("FAIL midrst_err_cleared: got %b want 0", err_oob); end
    for (int c = 0; c < 4; c++) begin
      tick; #1;
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL midrst_stale c=%0d: got %b want 0", c, resp_valid); end
    end
    for (int c = 0; c < 5; c++) begin
      tick; req_valid = 1'b1; req_data = 20 + accepted; #1;
      if (req_ready) accepted++;
    end
    checks++; if (accepted !== 4) begin errors++; $display("FAIL midrst_credits: got %0d want 4", accepted); end
    req_valid = 1'b0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      tick; resp_ready = 1'b1; #1;
      if (resp_valid) begin
        checks++; if (resp_data !== word(20 + got)) begin errors++; $display("FAIL midrst_order n=%0d: got %h want %h", got, resp_data, word(20 + got)); end
        got++;
      end
    end
    checks++; if (got !== 4) begin errors++; $display("FAIL midrst_resp_count: got %0d want 4", got); end
    tick; #1;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL midrst_drained: got %b want 0", resp_valid); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 1024; i++) sram[i] = 32'h1000_0000 + i;
    sram[5] = 32'hDEAD_BEEF;
    rst = 1'b1; req_valid = 1'b0; req_data = '0; resp_ready = 1'b0;
    test_reset;
    test_single;
    test_stream;
    test_backpressure;
    test_oob;
    test_midreset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
